// File: rtl/br_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : br_arb_pkg
// Description : Shared helpers for the br_arb family of arbiters: weight-field
//               width, effective-weight clamp and reset owner index.
// Revision    : 1.0 - initial release
// ============================================================================
package br_arb_pkg;

  // Width of one weight field able to hold values 0..max_weight.
  function automatic int weight_width(input int max_weight);
    return $clog2(max_weight + 1);
  endfunction

  // Weight 0 behaves as 1 (never starves); values above max_weight clamp.
  function automatic int eff_weight(input int w, input int max_weight);
    if (w == 0) begin
      return 1;
    end
    if (w > max_weight) begin
      return max_weight;
    end
    return w;
  endfunction

  // Owner after reset is the last requester so requester 0 wins first.
  function automatic int reset_owner(input int num_requesters);
    return num_requesters - 1;
  endfunction

endpackage : br_arb_pkg
`default_nettype wire

// File: rtl/br_arb_wrr_rotate.sv
`default_nettype none
// ============================================================================
// Module      : br_arb_wrr_rotate
// Description : Combinational rotating-priority selector. Returns the one-hot
//               position of the first set request bit, searching from start_i
//               upward and wrapping. Zero when no request is set.
// Revision    : 1.0 - initial release
// ============================================================================
module br_arb_wrr_rotate #(
  parameter int NumRequesters = 4
) (
  input  logic [NumRequesters-1:0]         request_i,
  input  logic [$clog2(NumRequesters)-1:0] start_i,
  output logic [NumRequesters-1:0]         grant_o
);

  localparam int IdxW = $clog2(NumRequesters);

  logic            found;
  logic [IdxW-1:0] idx;

  // Walk the requesters in rotated order and keep the first hit only.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      idx = IdxW'((int'(start_i) + i) % NumRequesters);
      if (!found && request_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule : br_arb_wrr_rotate
`default_nettype wire

// File: rtl/br_arb_wrr.sv
`default_nettype none
// ============================================================================
// Module      : br_arb_wrr
// Description : Weighted round-robin arbiter with zero-latency grant. The
//               current owner keeps the grant for up to its effective weight
//               of consecutive updates, then priority rotates past it.
//               Optional macro BR_ARB_WRR_LOCK_EN adds a lock input that pins
//               the grant on a still-requesting owner without spending credit.
// Revision    : 1.0 - initial release
// ============================================================================
module br_arb_wrr
  import br_arb_pkg::*;
#(
  parameter int NumRequesters = 4,
  parameter int MaxWeight     = 8,
  parameter int WeightWidth   = weight_width(MaxWeight)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enable_priority_update,
`ifdef BR_ARB_WRR_LOCK_EN
  input  logic                               lock,
`endif
  input  logic [NumRequesters-1:0]           request,
  input  logic [NumRequesters*WeightWidth-1:0] weight,
  output logic [NumRequesters-1:0]           grant
);

  localparam int              IdxW       = $clog2(NumRequesters);
  localparam logic [IdxW-1:0] ResetOwner = IdxW'(reset_owner(NumRequesters));
  localparam logic [IdxW-1:0] LastIdx    = IdxW'(NumRequesters - 1);

  logic [IdxW-1:0]          owner_q, owner_d;
  logic [WeightWidth-1:0]   credit_q, credit_d;

  logic                     owner_req;
  logic                     lock_hold;
  logic                     sticky;
  logic [IdxW-1:0]          rot_start;
  logic [NumRequesters-1:0] rot_grant;
  logic [IdxW-1:0]          gnt_idx;
  logic [WeightWidth-1:0]   w_sel;
  logic [WeightWidth-1:0]   reload;

  assign owner_req = request[owner_q];

`ifdef BR_ARB_WRR_LOCK_EN
  assign lock_hold = lock && owner_req;
`else
  assign lock_hold = 1'b0;
`endif

  // Owner keeps the grant while it still requests and has credit (or is locked).
  assign sticky    = owner_req && ((credit_q != '0) || lock_hold);

  // Owner itself is searched last, so the search begins one past it.
  assign rot_start = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

  br_arb_wrr_rotate #(
    .NumRequesters (NumRequesters)
  ) u_rotate (
    .request_i (request),
    .start_i   (rot_start),
    .grant_o   (rot_grant)
  );

  // Grant mux: forced idle in reset, otherwise sticky owner or rotated pick.
  always_comb begin
    grant = '0;
    if (!rst_n) begin
      grant = '0;
    end else if (sticky) begin
      grant[owner_q] = 1'b1;
    end else begin
      grant = rot_grant;
    end
  end

  // Encode the granted index and fetch its programmed weight for a reload.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NumRequesters; i++) begin
      if (grant[i]) begin
        gnt_idx = IdxW'(i);
      end
    end
    w_sel  = WeightWidth'(weight >> (gnt_idx * WeightWidth));
    reload = WeightWidth'(eff_weight(int'(w_sel), MaxWeight) - 1);
  end

  // Next owner/credit: spend credit on a repeat grant, reload on a hand-over.
  always_comb begin
    owner_d  = owner_q;
    credit_d = credit_q;
    if (enable_priority_update && (|grant)) begin
      if (lock_hold) begin
        credit_d = credit_q;
      end else if ((gnt_idx == owner_q) && (credit_q != '0)) begin
        credit_d = credit_q - 1'b1;
      end else begin
        owner_d  = gnt_idx;
        credit_d = reload;
      end
    end
  end

  // Owner/credit state registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= ResetOwner;
      credit_q <= '0;
    end else begin
      owner_q  <= owner_d;
      credit_q <= credit_d;
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));

  a_grant_subset : assert property (@(posedge clk) disable iff (!rst_n)
    (grant & ~request) == '0);

  a_grant_live : assert property (@(posedge clk) disable iff (!rst_n)
    (|request) |-> (|grant));

  a_inputs_known : assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({request, enable_priority_update}));

endmodule : br_arb_wrr
`default_nettype wire

// File: doc/br_arb_wrr.md
Name: br_arb_wrr

Overview:
- Weighted round-robin arbiter; parametrised successor to the plain round-robin arbiter.
- Each requester may hold a grant for up to its programmed weight of consecutive grant cycles before priority rotates.
- Grant is combinational (zero latency), same request→grant contract as the existing arbiters.
- Used in front of shared datapaths (crossbar egress, memory ports) needing bandwidth shaping.

Parameters:
- NumRequesters, 4, number of requesters; must be >= 2.
- MaxWeight, 8, largest programmable weight; must be >= 1.
- WeightWidth, $clog2(MaxWeight+1), derived width of each weight field; do not override.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- enable_priority_update  input  1  when 1, the current grant updates owner/credit state at the clock edge.
- request  input  NumRequesters  per-requester request.
- weight  input  NumRequesters*WeightWidth  per-requester weight; field i is bits [i*WeightWidth +: WeightWidth]; quasi-static.
- grant  output  NumRequesters  one-hot or zero grant.

Behaviour:
- State:
  - owner, index of the last updated grantee; reset NumRequesters-1, so requester 0 has top priority first.
  - credit, remaining back-to-back grants for owner; WeightWidth bits; reset 0.
- Grant, combinational:
  - If rst_n==0: grant=0.
  - Else if request[owner] && credit>0: grant = onehot(owner) (sticky).
  - Else: first set request bit searching owner+1, owner+2, … wrapping; owner itself is searched last.
  - request==0 → grant=0.
  - grant is never multi-hot.
- Update at posedge clk, only when enable_priority_update && |grant. Let g be the granted index:
  - g==owner and credit>0: credit <= credit-1.
  - Otherwise: owner <= g, credit <= eff_weight(g)-1.
  - eff_weight(w) = (w==0) ? 1 : min(w, MaxWeight). Weight 0 is never a starvation mechanism.
- No update (enable=0 or grant=0): owner and credit hold.
- Owner drops request mid-burst: priority rotates immediately that cycle. Unused credit is discarded when the new grantee reloads.
- Weight changes take effect at the next reload only; in-flight credit is not recomputed.
- All weights 1: behaviour is identical to plain round-robin.
- Fairness bound: a continuously requesting requester is granted within sum of other eff_weights update cycles.
- Async reset asserted mid-burst: state clears immediately; grant forced 0 until rst_n deasserts; first grant after release follows the reset state.
- Assertions:
  - grant onehot0.
  - grant subset of request.
  - |request → |grant when out of reset.
  - No X on request/enable outside reset.

Optional Feature:
- Macro BR_ARB_WRR_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - While lock==1 and request[owner]==1, grant = onehot(owner) regardless of credit.
  - Updates under lock leave credit unchanged. Supports multi-beat packets longer than the weight.
  - lock with request[owner]==0 is ignored; normal arbitration applies.
- When not defined: no lock port; behaviour exactly as above.

Decomposition:
- Shared package br_arb_pkg:
  - Weight-field width helper function.
  - eff_weight function.
  - Reset owner constant.
- One natural sub-module: br_arb_wrr_rotate, a combinational rotating-priority one-hot selector.
  - Inputs: request, start index. Output: one-hot grant.
  - Reused by future arbiters.
- Top block holds owner/credit flops, the sticky mux and the assertions.

Test Plan:
- N=4, all weights 1, request=1010, enable=1 for 3 cycles → grants 0010, 1000, 0010.
- Weights {w0=3,w1=1,w2=2,w3=1}, request=1111, enable=1 → grants 0001,0001,0001,0010,0100,0100,1000,0001.
- w0=2, request=0011, enable=0 for 3 cycles → grant 0001 constant with owner/credit unchanged; then enable=1 → 0001, 0001, 0010.
- w0=4, w2=2, request=0101, after 2 grants to 0 drive request=0100 → grant 0100 next cycle; then request=0101 → grants 0100, 0001 (w2 burst honoured).
- Weight 0 on all requesters, request=0011 → alternating 0001, 0010 (treated as 1); request=0000 → grant 0000, state unchanged.
- w0=3, request=1111, assert rst_n=0 asynchronously after 1 grant → grant 0 immediately. Release → grant 0001 with full 3-cycle burst.
- With BR_ARB_WRR_LOCK_EN: w1=1, request=0110, lock=1 for 4 cycles → 0010 ×4. Drop lock → 0100.
